// File: rtl/calc_pkg.sv
// Shared command codes, sequencer state type and code classification helpers.
package calc_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CMD_W  = CODE_W + 1;

  localparam logic [CODE_W-1:0] CMD_ADD = 4'b1010;
  localparam logic [CODE_W-1:0] CMD_SUB = 4'b1011;
  localparam logic [CODE_W-1:0] CMD_MUL = 4'b1100;
  localparam logic [CODE_W-1:0] CMD_NOP = 4'b1101;
  localparam logic [CODE_W-1:0] CMD_EQ  = 4'b1110;
  localparam logic [CODE_W-1:0] CMD_BSP = 4'b1111;

  // Hold classes returned by hold_class()
  localparam logic [1:0] CLS_DIGIT = 2'd0;
  localparam logic [1:0] CLS_OP    = 2'd1;
  localparam logic [1:0] CLS_EQ    = 2'd2;

  // Requester command payload: clear flag plus keypad code
  typedef struct packed {
    logic              clr;
    logic [CODE_W-1:0] code;
  } seq_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2,
    S_CLR  = 2'd3
  } seq_state_t;

  // Digits, backspace and NOP share the short hold; operators and equals are longer
  function automatic logic [1:0] hold_class(input logic [CODE_W-1:0] code);
    logic [1:0] cls;
    cls = CLS_DIGIT;
    case (code)
      CMD_ADD, CMD_SUB, CMD_MUL: cls = CLS_OP;
      CMD_EQ:                    cls = CLS_EQ;
      default:                   cls = CLS_DIGIT;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/calc_rr_arb2.sv
// Two-way round-robin arbiter; the caller owns the last-grant register.
module calc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // On contention the requester that was not served last wins
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    case (req)
      2'b01: begin
        gnt     = 2'b01;
        gnt_idx = 1'b0;
      end
      2'b10: begin
        gnt     = 2'b10;
        gnt_idx = 1'b1;
      end
      2'b11: begin
        if (last) begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end else begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
      end
      default: begin
        gnt     = 2'b00;
        gnt_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Arbitrates keypad/host commands and paces them onto the calculator cmd input.
module calc_cmd_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DIGIT_HOLD = 20,
  parameter int unsigned OP_HOLD    = 30,
  parameter int unsigned EQ_HOLD    = 100,
  parameter int unsigned GAP        = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [CMD_W-1:0]  a_cmd,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [CMD_W-1:0]  b_cmd,
  output logic              b_ready,
  output logic [CODE_W-1:0] cmd_out,
  output logic              calc_rst,
  output logic              busy,
  output logic              last_grant
);

  localparam logic [CNT_W-1:0] DIGIT_LD = CNT_W'(DIGIT_HOLD);
  localparam logic [CNT_W-1:0] OP_LD    = CNT_W'(OP_HOLD);
  localparam logic [CNT_W-1:0] EQ_LD    = CNT_W'(EQ_HOLD);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] cmd_d;
  logic              rst_d;
  logic              last_d;
  logic              busy_d;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              gnt_idx;
  seq_cmd_t          sel;

  // Hold length for a code, from its class
  function automatic logic [CNT_W-1:0] hold_load(input logic [CODE_W-1:0] code);
    logic [CNT_W-1:0] ld;
    case (hold_class(code))
      CLS_OP:  ld = OP_LD;
      CLS_EQ:  ld = EQ_LD;
      default: ld = DIGIT_LD;
    endcase
    return ld;
  endfunction

  // Requests are only considered while idle and out of reset
  assign req = (state_q == S_IDLE && !reset) ? {b_valid, a_valid} : 2'b00;

  calc_rr_arb2 u_arb (
    .req     (req),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel = gnt_idx ? seq_cmd_t'(b_cmd) : seq_cmd_t'(a_cmd);

  // Next-state, counter and next-output logic; readies are the only combinational outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_out;
    rst_d   = 1'b0;
    last_d  = last_grant;
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_d = CMD_NOP;
        if (|gnt) begin
          a_ready = gnt[0];
          b_ready = gnt[1];
          last_d  = gnt_idx;
          if (sel.clr) begin
            state_d = S_CLR;
            rst_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_HOLD;
            cmd_d   = sel.code;
            cnt_d   = hold_load(sel.code);
          end
        end
      end
      S_HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          cmd_d = CMD_NOP;
          if (GAP == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        cmd_d = CMD_NOP;
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CLR: begin
        cmd_d = CMD_NOP;
        if (GAP == 0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cmd_d   = CMD_NOP;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any command in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_out    <= CMD_NOP;
      calc_rst   <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_out    <= cmd_d;
      calc_rst   <= rst_d;
      last_grant <= last_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Scoreboard bench: accepted commands expand into a queue of expected output cycles.
module tb_calc_cmd_sequencer;
  import calc_pkg::*;

  localparam int GAPN = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0;
  logic [4:0] a_cmd = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [4:0] b_cmd = '0;
  logic       b_ready;
  logic [3:0] cmd_out;
  logic       calc_rst;
  logic       busy;
  logic       last_grant;

  always #5 clock = ~clock;

  calc_cmd_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_cmd      (a_cmd),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_cmd      (b_cmd),
    .b_ready    (b_ready),
    .cmd_out    (cmd_out),
    .calc_rst   (calc_rst),
    .busy       (busy),
    .last_grant (last_grant)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0] cmd;
    logic       rst;
  } exp_t;

  exp_t       exp_q[$];
  logic       m_last = 1'b1;
  exp_t       e;
  logic       ea, eb, ebusy;
  int         disp_cur = 0, disp_acc = 0, disp_op = -1;
  logic [3:0] prev_cmd = 4'hD;

  logic [4:0] a_q[$];
  logic [4:0] b_q[$];
  logic       a_took = 1'b0, b_took = 1'b0;
  bit         drop_en = 1'b0;

  function automatic int hold_of(input logic [3:0] c);
    if (c == 4'd10 || c == 4'd11 || c == 4'd12) return 30;
    if (c == 4'd14) return 100;
    return 20;
  endfunction

  // One accepted command becomes its exact future output cycles
  function automatic void push_seg(input logic [4:0] c);
    if (c[4]) exp_q.push_back('{cmd: 4'hD, rst: 1'b1});
    else for (int i = 0; i < hold_of(c[3:0]); i++) exp_q.push_back('{cmd: c[3:0], rst: 1'b0});
    for (int i = 0; i < GAPN; i++) exp_q.push_back('{cmd: 4'hD, rst: 1'b0});
  endfunction

  function automatic int apply(input int a, input int op, input int b);
    if (op == 10) return a + b;
    if (op == 11) return a - b;
    return a * b;
  endfunction

  // Minimal calculator reacting to each new key seen on cmd_out
  function automatic void key(input logic [3:0] k);
    if (k <= 4'd9) disp_cur = disp_cur * 10 + int'(k);
    else if (k == 4'd15) disp_cur = disp_cur / 10;
    else if (k == 4'd14) begin
      if (disp_op >= 0) disp_cur = apply(disp_acc, disp_op, disp_cur);
      disp_op = -1;
    end else begin
      disp_acc = (disp_op >= 0) ? apply(disp_acc, disp_op, disp_cur) : disp_cur;
      disp_op  = int'(k);
      disp_cur = 0;
    end
  endfunction

  function automatic void calc_clear();
    disp_cur = 0;
    disp_acc = 0;
    disp_op  = -1;
  endfunction

  // Monitor: compare every non-reset cycle against the expected-output queue
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      m_last   = 1'b1;
      prev_cmd = 4'hD;
      calc_clear();
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        ebusy = 1'b1;
        ea = 1'b0;
        eb = 1'b0;
      end else begin
        e = '{cmd: 4'hD, rst: 1'b0};
        ebusy = 1'b0;
        ea = a_valid && (!b_valid || m_last);
        eb = b_valid && (!a_valid || !m_last);
      end
      chk("cmd_out", 32'(cmd_out), 32'(e.cmd));
      chk("calc_rst", 32'(calc_rst), 32'(e.rst));
      chk("busy", 32'(busy), 32'(ebusy));
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("b_ready", 32'(b_ready), 32'(eb));
      chk("last_grant", 32'(last_grant), 32'(m_last));
      if (exp_q.size() > 0) exp_q.delete(0);
      else if (ea) begin
        m_last = 1'b0;
        push_seg(a_cmd);
      end else if (eb) begin
        m_last = 1'b1;
        push_seg(b_cmd);
      end
      if (calc_rst) calc_clear();
      if (cmd_out != 4'hD && prev_cmd == 4'hD) key(cmd_out);
      prev_cmd = cmd_out;
    end
  end

  // One clock of stimulus: retire accepted commands, drive the next ones
  task automatic step(input logic rst_v);
    @(posedge clock);
    #1;
    reset = rst_v;
    if (a_took) a_q.delete(0);
    if (b_took) b_q.delete(0);
    a_valid = (a_q.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
    a_cmd   = (a_q.size() > 0) ? a_q[0] : 5'd0;
    b_valid = (b_q.size() > 0) && (!drop_en || $urandom_range(0, 3) != 0);
    b_cmd   = (b_q.size() > 0) ? b_q[0] : 5'd0;
    @(negedge clock);
    a_took = a_valid && a_ready && !reset;
    b_took = b_valid && b_ready && !reset;
  endtask

  task automatic run_idle(input int budget, input string name);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      step(1'b0);
      k++;
      done = (a_q.size() == 0) && (b_q.size() == 0) && !a_took && !b_took && (busy == 1'b0);
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    logic [4:0] r;
    int         k;
    repeat (3) step(1'b1);

    a_q = '{5'h01, 5'h02, 5'h03, 5'h0A, 5'h01, 5'h0E};
    run_idle(2000, "expr");
    chk("disp_124", 32'(disp_cur), 32'd124);

    b_q.push_back(5'h10);
    run_idle(200, "clr1");
    chk("disp_clr1", 32'(disp_cur), 32'd0);
    a_q.push_back(5'h05);
    b_q.push_back(5'h06);
    run_idle(500, "contend");
    chk("disp_56", 32'(disp_cur), 32'd56);
    chk("last_grant_b", 32'(last_grant), 32'd1);

    for (int i = 0; i < 4; i++) begin
      a_q.push_back(5'(i));
      b_q.push_back(5'(i + 4));
    end
    run_idle(1000, "alternate");

    b_q.push_back(5'h1A);
    run_idle(200, "clr2");
    a_q = '{5'h04, 5'h05, 5'h06, 5'h0F};
    run_idle(1000, "bsp");
    chk("disp_45", 32'(disp_cur), 32'd45);
    b_q.push_back(5'h13);
    run_idle(200, "clr3");
    chk("disp_clr3", 32'(disp_cur), 32'd0);

    a_q.push_back(5'h0E);
    k = 0;
    while (busy !== 1'b1 && k < 20) begin
      step(1'b0);
      k++;
    end
    chk("eq_started", 32'(busy), 32'd1);
    repeat (10) step(1'b0);
    a_q.push_back(5'h07);
    step(1'b1);
    step(1'b0);
    chk("post_rst_accept", 32'(a_took), 32'd1);
    run_idle(500, "post_rst");
    chk("disp_7", 32'(disp_cur), 32'd7);

    drop_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = ($urandom_range(0, 15) == 0) ? {1'b1, 4'($urandom)} : {1'b0, 4'($urandom)};
      a_q.push_back(r);
      r = ($urandom_range(0, 15) == 0) ? {1'b1, 4'($urandom)} : {1'b0, 4'($urandom)};
      b_q.push_back(r);
    end
    run_idle(40000, "random");
    drop_en = 1'b0;
    repeat (3) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
